// File: rtl/uctl_wptr_full.sv
// uctl_wptr_full: write-domain pointer and status logic of the USB controller async FIFO.
// Optional sticky overflow flag enabled by defining UCTL_WFIFO_OVF_EN.
// Ports:
//   wclk, wrst_n  write clock, async active-low reset
//   winc          write request (accepted when wfull=0)
//   wq2_rptr      Gray read pointer, already synchronised into wclk
//   waddr         binary RAM write address
//   wptr          registered Gray write pointer to the read domain
//   wfull/wafull  full / almost-full flags
//   wlevel        write-side fill level 0..depth
//   wovf/wovf_clr sticky overflow flag and its clear
module uctl_wptr_full #(
   parameter int unsigned FIFO_ADDRSIZE = 2,
   parameter int unsigned AFULL_THRESH  = 3
) (
   input  logic                     wclk,
   input  logic                     wrst_n,
   input  logic                     winc,
   input  logic [FIFO_ADDRSIZE:0]   wq2_rptr,
   output logic [FIFO_ADDRSIZE-1:0] waddr,
   output logic [FIFO_ADDRSIZE:0]   wptr,
   output logic                     wfull,
   output logic                     wafull,
   output logic [FIFO_ADDRSIZE:0]   wlevel,
   output logic                     wovf,
   input  logic                     wovf_clr
);

   localparam int unsigned AW = FIFO_ADDRSIZE;
   localparam int unsigned PW = FIFO_ADDRSIZE + 1;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] wlevel_q, wlevel_d;
   logic          wfull_q, wfull_d;
   logic          wafull_q, wafull_d;
   logic          wpush_c;
   logic [PW-1:0] rbin_c;

   // Next pointer, Gray conversion, read pointer decode and status
   always_comb begin
      wpush_c  = winc & ~wfull_q;
      wbin_d   = wbin_q + PW'(wpush_c);
      wptr_d   = (wbin_d >> 1) ^ wbin_d;
      rbin_c   = '0;
      rbin_c[PW-1] = wq2_rptr[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         rbin_c[i] = rbin_c[i+1] ^ wq2_rptr[i];
      end
      wlevel_d = wbin_d - rbin_c;
      // Full when next write pointer equals read pointer with the two MSBs inverted
      wfull_d  = (wptr_d == {~wq2_rptr[PW-1 -: 2], wq2_rptr[PW-3:0]});
      wafull_d = (wlevel_d >= PW'(AFULL_THRESH));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         wlevel_q <= wlevel_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
      end
   end

   assign waddr  = wbin_q[AW-1:0];
   assign wptr   = wptr_q;
   assign wlevel = wlevel_q;
   assign wfull  = wfull_q;
   assign wafull = wafull_q;

`ifdef UCTL_WFIFO_OVF_EN
   logic wovf_q, wovf_d;

   // Sticky overflow: a rejected write sets, clear only wins when no set
   always_comb begin
      wovf_d = (winc & wfull_q) | (wovf_q & ~wovf_clr);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) wovf_q <= 1'b0;
      else         wovf_q <= wovf_d;
   end

   assign wovf = wovf_q;
`else
   logic unused_wovf_clr;
   assign unused_wovf_clr = wovf_clr;
   assign wovf = 1'b0;
`endif

endmodule
